// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that issues MD starts.
package md_pkg;

    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMthi  = 3'd5,
        MdMtlo  = 3'd6
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned DefaultMultCycles = 5;
    localparam int unsigned DefaultDivCycles  = 10;
    localparam int unsigned DefaultCntW       = 4;

endpackage

// File: rtl/md_compute.sv
// Combinational signed/unsigned multiply and divide producing the pending HI/LO pair.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_p,
    output logic [31:0] lo_p,
    output logic        div_by_zero
);

    md_op_e      op;
    logic        signed_div;
    logic [31:0] b_safe;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [63:0] prod;

    assign op = md_op_e'(md_op);

    always_comb begin
        hi_p        = '0;
        lo_p        = '0;
        div_by_zero = 1'b0;
        prod        = '0;
        // Divisor forced to 1 on zero so the divider never produces X; result is discarded.
        b_safe      = (B == 32'd0) ? 32'd1 : B;
        signed_div  = (op == MdDiv);
        num         = (signed_div && A[31]) ? -A : A;
        den         = (signed_div && b_safe[31]) ? -b_safe : b_safe;
        q_mag       = num / den;
        r_mag       = num % den;

        case (op)
            MdMult: begin
                prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
                hi_p = prod[63:32];
                lo_p = prod[31:0];
            end
            MdMultu: begin
                prod = {32'd0, A} * {32'd0, B};
                hi_p = prod[63:32];
                lo_p = prod[31:0];
            end
            MdDiv: begin
                div_by_zero = (B == 32'd0);
                lo_p        = (A[31] ^ b_safe[31]) ? -q_mag : q_mag;
                hi_p        = A[31] ? -r_mag : r_mag;
            end
            MdDivu: begin
                div_by_zero = (B == 32'd0);
                lo_p        = q_mag;
                hi_p        = r_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, then commit to HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefaultMultCycles,
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles,
    parameter int unsigned CNT_W       = DefaultCntW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_p_q, hi_p_d;
    logic [31:0]      lo_p_q, lo_p_d;
    logic             dbz_q, dbz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;

    logic [31:0] hi_c;
    logic [31:0] lo_c;
    logic        dbz_c;

    md_compute u_compute (
        .md_op       (md_op),
        .A           (A),
        .B           (B),
        .hi_p        (hi_c),
        .lo_p        (lo_c),
        .div_by_zero (dbz_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MdMult, MdMultu: begin
                            hi_p_d  = hi_c;
                            lo_p_d  = lo_c;
                            dbz_d   = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = StRun;
                        end
                        MdDiv, MdDivu: begin
                            hi_p_d  = hi_c;
                            lo_p_d  = lo_c;
                            dbz_d   = dbz_c;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            state_d = StRun;
                        end
                        MdMthi:  hi_d = A;
                        MdMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Starts arriving here are dropped; the in-flight result is untouched.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!dbz_q) begin
                        hi_d = hi_p_q;
                        lo_d = lo_p_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences, random vs model.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Architectural reference using 64-bit integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint          p;
        longint unsigned pu;
        longint          q;
        longint          r;
        case (op)
            3'd1: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                hi = pu[63:32];
                lo = pu[31:0];
            end
            3'd3: if (b != 0) begin
                q  = longint'($signed(a)) / longint'($signed(b));
                r  = longint'($signed(a)) % longint'($signed(b));
                hi = r[31:0];
                lo = q[31:0];
            end
            3'd4: if (b != 0) begin
                hi = a % b;
                lo = a / b;
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endtask

    // Issues one start and checks the whole busy/done/commit window.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ex_hi,
                          input logic [31:0] ex_lo);
        int n;
        n     = latency(op);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        check({name, " busy_at_start"}, 32'(busy), 32'd0);
        check({name, " hi_no_bypass"}, HI, mdl_hi);
        tick();
        start = 1'b0;
        md_op = 3'd0;
        for (int i = 0; i < n; i++) begin
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " done_early"}, 32'(done), 32'd0);
            check({name, " hi_hold"}, HI, mdl_hi);
            check({name, " lo_hold"}, LO, mdl_lo);
            tick();
        end
        mdl_hi = ex_hi;
        mdl_lo = ex_lo;
        check({name, " busy_end"}, 32'(busy), 32'd0);
        check({name, " done"}, 32'(done), (n > 0) ? 32'd1 : 32'd0);
        check({name, " hi"}, HI, mdl_hi);
        check({name, " lo"}, LO, mdl_lo);
        if (n > 0) begin
            tick();
            check({name, " done_once"}, 32'(done), 32'd0);
            check({name, " stay_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;

        vecs[0]  = '{"mult_neg",    3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"divu",        3'd4, 32'd7,        32'd2,        32'd1,        32'd3};
        vecs[2]  = '{"div_neg",     3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"mthi",        3'd5, 32'h11,       32'd0,        32'h11,       32'hFFFFFFFD};
        vecs[4]  = '{"mtlo",        3'd6, 32'h22,       32'd0,        32'h11,       32'h22};
        vecs[5]  = '{"div_zero",    3'd3, 32'd5,        32'd0,        32'h11,       32'h22};
        vecs[6]  = '{"mthi_dead",   3'd5, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h22};
        vecs[7]  = '{"mtlo_2",      3'd6, 32'h12345678, 32'd0,        32'hDEADBEEF, 32'h12345678};
        vecs[8]  = '{"div_ovf",     3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[9]  = '{"multu_max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{"op_none",     3'd0, 32'h55,       32'h66,       32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{"op_unused",   3'd7, 32'h77,       32'h88,       32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = '0;
        B     = '0;
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // Start during RUN must be ignored.
        start = 1'b1;
        md_op = 3'd2;
        A     = 32'd2;
        B     = 32'd3;
        tick();
        for (int i = 1; i <= 5; i++) begin
            check("run_start busy", 32'(busy), 32'd1);
            start = (i == 2);
            md_op = (i == 2) ? 3'd3 : 3'd0;
            A     = 32'd9;
            B     = 32'd3;
            tick();
        end
        start  = 1'b0;
        md_op  = 3'd0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd6;
        check("run_start busy_end", 32'(busy), 32'd0);
        check("run_start done", 32'(done), 32'd1);
        check("run_start hi", HI, mdl_hi);
        check("run_start lo", LO, mdl_lo);
        tick();
        check("run_start no_restart", 32'(busy), 32'd0);
        check("run_start done_once", 32'(done), 32'd0);

        // Asynchronous reset in busy cycle 3 aborts the multiply.
        start = 1'b1;
        md_op = 3'd1;
        A     = 32'd4;
        B     = 32'd4;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        tick();
        tick();
        check("rst_mid busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid hi", HI, 32'd0);
        check("rst_mid lo", LO, 32'd0);
        tick();
        reset  = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rst_mid idle_busy", 32'(busy), 32'd0);
            check("rst_mid no_done", 32'(done), 32'd0);
            check("rst_mid no_commit", LO, 32'd0);
        end

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            eh = mdl_hi;
            el = mdl_lo;
            model(op, a, b, eh, el);
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, eh, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
